// File: rtl/mem_port.sv
// rtl/mem_port.sv - byte/half/word load-store port onto a big-endian fin-handshake memory; optional MEM_PORT_TIMEOUT_EN
module mem_port #(
    parameter int MEM_SIZE    = 65536,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic        cmd_unsigned,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_fin,
    input  logic [31:0] rd_data,
    output logic        wr_req,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    input  logic        wr_fin
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_DROP,
        WR,
        WR_DROP,
        RESP
    } state_t;

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_SIZE);

    state_t state, state_nxt;

    // Command fields kept for the later phases; the word-store data goes straight into wr_data.
    logic        lat_we;
    logic        lat_unsigned;
    logic [1:0]  lat_size;
    logic [15:0] lat_wdata;
    logic [31:0] cap_q;

    logic        rd_req_nxt, wr_req_nxt, rsp_valid_nxt, rsp_err_nxt;
    logic [31:0] rsp_rdata_nxt, rd_addr_nxt, wr_addr_nxt, wr_data_nxt, cap_nxt;
    logic        accept;
    logic        cmd_bad;
    logic        busy;
    logic        tmo_hit;

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                             input logic uns);
        logic fill;
        fill = w[31] & ~uns;
        case (sz)
            2'd0:    load_ext = {{24{fill}}, w[31:24]};
            2'd1:    load_ext = {{16{fill}}, w[31:16]};
            default: load_ext = w;
        endcase
    endfunction

    // Sub-word stores land on the most significant lanes, since addr+0 is bits 31:24.
    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [15:0] wd);
        if (sz == 2'd0) store_merge = {wd[7:0], w[23:0]};
        else            store_merge = {wd[15:0], w[15:0]};
    endfunction

    assign cmd_ready = (state == IDLE) && !rd_fin && !wr_fin;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state == RD) || (state == RD_DROP) || (state == WR) || (state == WR_DROP);

    // The range test is done 33 bits wide so an address near 2^32 cannot wrap into range.
    assign cmd_bad = (cmd_size == 2'd3)
                  || ((cmd_size == 2'd1) && cmd_addr[0])
                  || ((cmd_size == 2'd2) && (cmd_addr[1:0] != 2'b00))
                  || (({1'b0, cmd_addr} + 33'd3) >= MEM_LIMIT);

`ifdef MEM_PORT_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYC);
    logic [7:0] tmo_cnt;

    // Cycles spent in the current wait state; restarts whenever the state moves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                           tmo_cnt <= 8'd0;
        else if (!busy || state_nxt != state)   tmo_cnt <= 8'd0;
        else                                    tmo_cnt <= tmo_cnt + 8'd1;
    end

    assign tmo_hit = busy && (tmo_cnt == TMO_LIMIT);
`else
    assign tmo_hit = 1'b0;
`endif

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt     = state;
        rd_req_nxt    = rd_req;
        wr_req_nxt    = wr_req;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = 32'd0;
        rd_addr_nxt   = rd_addr;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        cap_nxt       = cap_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_bad) begin
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                    end else if (cmd_we && (cmd_size == 2'd2)) begin
                        state_nxt   = WR;
                        wr_req_nxt  = 1'b1;
                        wr_addr_nxt = cmd_addr;
                        wr_data_nxt = cmd_wdata;
                    end else begin
                        state_nxt   = RD;
                        rd_req_nxt  = 1'b1;
                        rd_addr_nxt = cmd_addr;
                    end
                end
            end
            RD: begin
                if (rd_fin) begin
                    state_nxt  = RD_DROP;
                    rd_req_nxt = 1'b0;
                    cap_nxt    = rd_data;
                end
            end
            RD_DROP: begin
                if (!rd_fin) begin
                    if (!lat_we) begin
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_rdata_nxt = load_ext(cap_q, lat_size, lat_unsigned);
                    end else if (!wr_fin) begin
                        // Hold off the write request until a stale wr_fin has gone away.
                        state_nxt   = WR;
                        wr_req_nxt  = 1'b1;
                        wr_addr_nxt = rd_addr;
                        wr_data_nxt = store_merge(cap_q, lat_size, lat_wdata);
                    end
                end
            end
            WR: begin
                if (wr_fin) begin
                    state_nxt  = WR_DROP;
                    wr_req_nxt = 1'b0;
                end
            end
            WR_DROP: begin
                if (!wr_fin) begin
                    state_nxt     = RESP;
                    rsp_valid_nxt = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt  = IDLE;
                rd_req_nxt = 1'b0;
                wr_req_nxt = 1'b0;
            end
        endcase
        if (tmo_hit) begin
            state_nxt     = RESP;
            rd_req_nxt    = 1'b0;
            wr_req_nxt    = 1'b0;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_rdata_nxt = 32'd0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Registered memory-side and response outputs plus the captured read word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_req    <= 1'b0;
            wr_req    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            rd_addr   <= 32'd0;
            wr_addr   <= 32'd0;
            wr_data   <= 32'd0;
            cap_q     <= 32'd0;
        end else begin
            rd_req    <= rd_req_nxt;
            wr_req    <= wr_req_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rd_addr   <= rd_addr_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
            cap_q     <= cap_nxt;
        end
    end

    // Command fields are captured on acceptance only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_we       <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_size     <= 2'd0;
            lat_wdata    <= 16'd0;
        end else if (accept) begin
            lat_we       <= cmd_we;
            lat_unsigned <= cmd_unsigned;
            lat_size     <= cmd_size;
            lat_wdata    <= cmd_wdata[15:0];
        end
    end

endmodule

// File: tb/tb_mem_port.sv
// tb/tb_mem_port.sv - directed self-checking bench for mem_port
module tb_mem_port;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic        cmd_unsigned = 1'b0;
    logic [1:0]  cmd_size = 2'd0;
    logic [31:0] cmd_addr = 32'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_fin = 1'b0;
    logic [31:0] rd_data = 32'd0;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_fin = 1'b0;

    mem_port dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_unsigned(cmd_unsigned), .cmd_size(cmd_size), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .rd_req(rd_req), .rd_addr(rd_addr), .rd_fin(rd_fin),
        .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_fin(wr_fin)
    );

    logic [7:0]  mem [0:255];
    int          checks = 0;
    int          failures = 0;
    bit          hold_rd_fin = 1'b0;
    bit          wr_stall = 1'b0;
    bit          overlap = 1'b0;
    bit          rd_seen = 1'b0;
    bit          wr_seen = 1'b0;
    int          rd_txn = 0;
    int          wr_txn = 0;
    logic [31:0] last_wr_data = 32'd0;

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder: big-endian, addr+0 on bits 31:24, fins on the falling edge.
    initial begin : responder
        logic [7:0] a;
        forever begin
            @(negedge clk);
            if (rd_req && wr_req) overlap = 1'b1;
            if (rd_req) rd_seen = 1'b1;
            if (wr_req) wr_seen = 1'b1;
            if (rd_req && !rd_fin) begin
                a = rd_addr[7:0];
                rd_data = {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
                rd_fin = 1'b1;
                rd_txn++;
            end else if (!rd_req && rd_fin && !hold_rd_fin) begin
                rd_fin = 1'b0;
            end
            if (wr_req && !wr_fin && !wr_stall) begin
                a = wr_addr[7:0];
                {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]} = wr_data;
                last_wr_data = wr_data;
                wr_fin = 1'b1;
                wr_txn++;
            end else if (!wr_req && wr_fin) begin
                wr_fin = 1'b0;
            end
        end
    end

    task automatic run_cmd(input logic we, input logic uns, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rdata, output logic err, output int lat);
        int n;
        bit got;
        rdata = 32'hBAD0BAD0;
        err   = 1'bx;
        @(negedge clk);
        rd_seen = 1'b0;
        wr_seen = 1'b0;
        cmd_we = we; cmd_unsigned = uns; cmd_size = sz; cmd_addr = addr; cmd_wdata = wd;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got   = 1'b1;
                rdata = rsp_rdata;
                err   = rsp_err;
            end else begin
                lat++;
            end
        end
        check("rsp_seen", 32'(got), 32'd1);
        @(negedge clk);
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    endtask

    initial begin : stimulus
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          r0, w0, cnt;
        bit          tmo_rsp;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]} = 32'hDEADBEEF;
        mem[8'h21] = 8'h80;
        {mem[8'h30], mem[8'h31]} = 16'h9ABC;
        {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} = 32'hAABBCCDD;
        {mem[8'h50], mem[8'h51], mem[8'h52], mem[8'h53]} = 32'h11223344;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_wr_req", 32'(wr_req), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Word load
        r0 = rd_txn; w0 = wr_txn;
        run_cmd(1'b0, 1'b0, 2'd2, 32'h10, 32'h0, rd, er, lat);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_err", 32'(er), 32'd0);
        check("lw_rd_txn", 32'(rd_txn - r0), 32'd1);
        check("lw_no_wr", 32'(wr_seen), 32'd0);
        check("lw_latency", 32'(lat), 32'd2);

        // Byte loads, signed and unsigned; half loads
        run_cmd(1'b0, 1'b0, 2'd0, 32'h21, 32'h0, rd, er, lat);
        check("lb_signed", rd, 32'hFFFFFF80);
        run_cmd(1'b0, 1'b1, 2'd0, 32'h21, 32'h0, rd, er, lat);
        check("lb_unsigned", rd, 32'h00000080);
        run_cmd(1'b0, 1'b0, 2'd1, 32'h30, 32'h0, rd, er, lat);
        check("lh_signed", rd, 32'hFFFF9ABC);
        run_cmd(1'b0, 1'b1, 2'd1, 32'h30, 32'h0, rd, er, lat);
        check("lh_unsigned", rd, 32'h00009ABC);

        // Half store: read-modify-write
        r0 = rd_txn; w0 = wr_txn;
        run_cmd(1'b1, 1'b0, 2'd1, 32'h40, 32'hFFFF1234, rd, er, lat);
        check("sh_err", 32'(er), 32'd0);
        check("sh_rdata_zero", rd, 32'd0);
        check("sh_wr_data", last_wr_data, 32'h1234CCDD);
        check("sh_rd_txn", 32'(rd_txn - r0), 32'd1);
        check("sh_wr_txn", 32'(wr_txn - w0), 32'd1);
        run_cmd(1'b0, 1'b0, 2'd2, 32'h40, 32'h0, rd, er, lat);
        check("sh_readback", rd, 32'h1234CCDD);

        // Byte store
        run_cmd(1'b1, 1'b0, 2'd0, 32'h50, 32'hFFFFFF5A, rd, er, lat);
        check("sb_wr_data", last_wr_data, 32'h5A223344);

        // Word store: no read phase
        r0 = rd_txn;
        run_cmd(1'b1, 1'b0, 2'd2, 32'h60, 32'hCAFEF00D, rd, er, lat);
        check("sw_no_rd", 32'(rd_txn - r0), 32'd0);
        run_cmd(1'b0, 1'b0, 2'd2, 32'h60, 32'h0, rd, er, lat);
        check("sw_readback", rd, 32'hCAFEF00D);

        // Error cases: immediate response, no memory request
        run_cmd(1'b0, 1'b0, 2'd2, 32'h13, 32'h0, rd, er, lat);
        check("e_misal_err", 32'(er), 32'd1);
        check("e_misal_lat", 32'(lat), 32'd0);
        check("e_misal_noreq", 32'(rd_seen | wr_seen), 32'd0);
        check("e_misal_rdata", rd, 32'd0);
        run_cmd(1'b0, 1'b0, 2'd2, 32'hFFFE, 32'h0, rd, er, lat);
        check("e_top_err", 32'(er), 32'd1);
        check("e_top_lat", 32'(lat), 32'd0);
        check("e_top_noreq", 32'(rd_seen | wr_seen), 32'd0);
        run_cmd(1'b0, 1'b0, 2'd0, 32'hFFFD, 32'h0, rd, er, lat);
        check("e_range_byte", 32'(er), 32'd1);
        run_cmd(1'b0, 1'b0, 2'd1, 32'h41, 32'h0, rd, er, lat);
        check("e_half_odd", 32'(er), 32'd1);
        run_cmd(1'b1, 1'b0, 2'd3, 32'h10, 32'h0, rd, er, lat);
        check("e_size3", 32'(er), 32'd1);
        check("e_size3_noreq", 32'(rd_seen | wr_seen), 32'd0);
        run_cmd(1'b0, 1'b0, 2'd2, 32'hFFFC, 32'h0, rd, er, lat);
        check("top_word_ok", 32'(er), 32'd0);

        // Reset during RD with rd_fin held high
        hold_rd_fin = 1'b1;
        @(negedge clk);
        cmd_we = 1'b0; cmd_size = 2'd2; cmd_addr = 32'h10; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("mid_rd_req", 32'(rd_req), 32'd1);
        @(negedge clk);
        #2;
        check("mid_rd_fin", 32'(rd_fin), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_drop", 32'(rd_req), 32'd0);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("mid_ready_low", 32'(cmd_ready), 32'd0);
            check("mid_no_req", 32'(rd_req), 32'd0);
        end
        hold_rd_fin = 1'b0;
        @(negedge clk);
        #1;
        check("mid_ready_back", 32'(cmd_ready), 32'd1);
        run_cmd(1'b0, 1'b0, 2'd2, 32'h10, 32'h0, rd, er, lat);
        check("post_rst_load", rd, 32'hDEADBEEF);

`ifdef MEM_PORT_TIMEOUT_EN
        // Write responder that never finishes
        wr_stall = 1'b1;
        @(negedge clk);
        cmd_we = 1'b1; cmd_size = 2'd2; cmd_addr = 32'h70; cmd_wdata = 32'h1; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cnt = 0;
        tmo_rsp = 1'b0;
        er = 1'b0;
        for (int i = 0; i < 400 && !tmo_rsp; i++) begin
            @(negedge clk);
            if (wr_req) cnt++;
            if (rsp_valid) begin
                tmo_rsp = 1'b1;
                er = rsp_err;
            end
        end
        check("tmo_rsp", 32'(tmo_rsp), 32'd1);
        check("tmo_err", 32'(er), 32'd1);
        check("tmo_len", 32'(cnt >= 255 && cnt <= 257), 32'd1);
        check("tmo_req_low", 32'(wr_req), 32'd0);
        wr_stall = 1'b0;
        repeat (2) @(negedge clk);
`else
        cnt = 0;
        tmo_rsp = 1'b0;
`endif

        check("no_overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port.md
MEM_PORT -- requirements
Module: mem_port

Interface
REQ-001 Parameter MEM_SIZE, default 65536, memory size in bytes used for the bounds check.
REQ-002 Parameter TIMEOUT_CYC, default 255, maximum cycles to wait for a fin; used only when MEM_PORT_TIMEOUT_EN is defined.
REQ-003 Port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 Port reset_n, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 Ports cmd_valid, cmd_ready, input/output, 1 each: command handshake.
REQ-006 Ports cmd_we, cmd_unsigned, input, 1 each: 1 = store / 1 = zero-extend load.
REQ-007 Port cmd_size, input, 2: 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-008 Ports cmd_addr, cmd_wdata, input, 32 each: byte address and store data (right-justified).
REQ-009 Ports rsp_valid, rsp_err, output, 1 each: completion pulse and error flag.
REQ-010 Port rsp_rdata, output, 32: extended load data.
REQ-011 Ports rd_req, rd_addr, output, 1/32: memory read request and address.
REQ-012 Ports rd_fin, rd_data, input, 1/32: read done; big-endian data, where addr+0 maps to bits 31:24.
REQ-013 Ports wr_req, wr_addr, wr_data, output, 1/32/32: memory write request, address and data (big-endian).
REQ-014 Port wr_fin, input, 1: write done.

Function
REQ-015 The FSM SHALL use states IDLE, RD, RD_DROP, WR, WR_DROP and RESP.
REQ-016 cmd_ready SHALL be high only in IDLE while rd_fin=0 and wr_fin=0; a command is accepted when cmd_valid and cmd_ready are both high, and all cmd_* fields SHALL be latched on acceptance.
REQ-017 Error conditions SHALL be:
- cmd_size=3;
- half with addr[0]=1;
- word with addr[1:0]≠0;
- addr+3 ≥ MEM_SIZE.
On error the FSM SHALL go directly to RESP with rsp_err=1 and make no memory access.
REQ-018 Load and sub-word store SHALL go to RD; word store SHALL go to WR.
REQ-019 In RD, rd_req SHALL be 1 and rd_addr SHALL equal the latched address.
- On the first cycle with rd_fin=1, rd_data SHALL be captured and the FSM SHALL go to RD_DROP with rd_req=0.
REQ-020 In RD_DROP the FSM SHALL wait for rd_fin=0.
- Then a load SHALL go to RESP.
- A sub-word store SHALL go to WR with wr_data equal to the captured word with bits 31:24 (byte) or 31:16 (half) replaced by cmd_wdata[7:0] or [15:0].
REQ-021 In WR, wr_req SHALL be 1; on wr_fin=1 the FSM SHALL go to WR_DROP with wr_req=0, and WR_DROP SHALL wait for wr_fin=0, then go to RESP.
REQ-022 rd_req and wr_req SHALL never be high simultaneously, and neither SHALL rise while its fin is high.
REQ-023 rsp_rdata SHALL be:
- byte: captured[31:24] extended;
- half: captured[31:16] extended;
- word: captured unchanged.
Extension is sign unless cmd_unsigned=1; rsp_rdata SHALL be 0 for stores and errors.
REQ-024 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE; cmd_valid in RESP SHALL be ignored.
REQ-025 req is a registered output; response latency is one cycle after the final fin fall.

Reset
REQ-026 When reset_n=0, the block SHALL asynchronously force state=IDLE and all of the following to 0: rd_req, wr_req, rsp_valid, rsp_err, rsp_rdata, rd_addr, wr_addr, wr_data and the timeout counter.
REQ-027 Reset mid-transaction SHALL drop the request immediately; after reset, no command SHALL be accepted until both fins read 0 (REQ-016).

Configuration
REQ-028 When macro MEM_PORT_TIMEOUT_EN is defined:
- an 8-bit counter SHALL count cycles in RD, RD_DROP, WR and WR_DROP;
- when the counter reaches TIMEOUT_CYC, the active req SHALL drop and the FSM SHALL go to RESP with rsp_err=1;
- the counter SHALL clear on each state change.
REQ-029 Without MEM_PORT_TIMEOUT_EN, no counter SHALL exist and the waits SHALL be unbounded.

Verification
REQ-030 Word load at addr 0x10, memory holds 0xDEADBEEF -> one rd_req transaction, rsp_rdata=0xDEADBEEF, rsp_err=0, wr_req never high.
REQ-031 Signed byte load at 0x21, byte 0x80 -> rsp_rdata=0xFFFFFF80; the same load with cmd_unsigned=1 -> 0x00000080.
REQ-032 Half store of 0x1234 at 0x40, memory word 0xAABBCCDD -> read then write, wr_data=0x1234CCDD, memory reads back 0x1234CCDD.
REQ-033 Word load at 0x13 and word load at MEM_SIZE-2 -> rsp_err=1, rsp_valid pulse one cycle after accept, no req asserted.
REQ-034 reset_n pulsed low during RD with a responder that holds rd_fin=1 -> rd_req=0 at once, cmd_ready=0 until rd_fin=0.
REQ-035 With MEM_PORT_TIMEOUT_EN defined, a responder that never asserts wr_fin -> wr_req drops after 255 cycles and rsp_err=1.
